// File: rtl/i2c_defs.sv
// Shared definitions for the I2C receive front end and the command processor.
package i2c_defs;

  // Receive FSM state encodings.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_DATA     = 3'd3,
    ST_DATA_ACK = 3'd4,
    ST_IGNORE   = 3'd5
  } i2c_state_e;

  // Address this slave answers to unless overridden at instantiation.
  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h42;

  // Command IDs understood by the command processor.
  localparam logic [7:0] CMD_CIRCLE       = 8'd1;
  localparam logic [7:0] CMD_ELLIPSE      = 8'd2;
  localparam logic [7:0] CMD_LINE_DRAW    = 8'd4;
  localparam logic [7:0] CMD_TEST_PATTERN = 8'd8;
  localparam logic [7:0] CMD_SOFT_RESET   = 8'd16;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO. DEPTH must be a power of 2 so the pointers wrap
// naturally. A push into a full FIFO is dropped even when a pop happens in
// the same cycle. While empty, data_o holds the last entry popped.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = empty_o ? last_q : mem_q[rd_ptr_q];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        last_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave: synchronizes SCL/SDA, matches the 7-bit address,
// ACKs data bytes into a FIFO and latches the first byte of each write as cmd.
// Output handshake: a byte transfers in every cycle where out_rts and out_rtr
// are both high; out_data is only meaningful while out_rts is high.
module i2c_slave_rx
  import i2c_defs::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst_,
  input  logic                        scl_in,
  input  logic                        sda_in,
  output logic                        sda_oe,
  output logic                        out_rts,
  input  logic                        out_rtr,
  output logic [7:0]                  out_data,
  output logic [7:0]                  cmd,
  output logic                        busy,
  output logic                        overflow,
  input  logic                        ovf_clr,
  output i2c_state_e                  state_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_det;
  logic                   stop_det;

  i2c_state_e state_q;
  logic [2:0] bit_cnt_q;
  logic       byte_rdy_q;
  logic [7:0] shift_q;
  logic       sda_oe_q;
  logic       first_q;
  logic [7:0] cmd_q;
  logic       busy_q;
  logic       ovf_q;

  logic       fifo_full;
  logic       fifo_empty;
  logic       push_w;

  // Synchronizers plus one history flop per line; the bus idles high.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  // A completed data byte is pushed on the falling edge that ends its 8th bit.
  assign push_w = (state_q == ST_DATA) & scl_fall & byte_rdy_q & ~fifo_full;

  // Protocol FSM; START/STOP take priority over whatever state we are in.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      byte_rdy_q <= 1'b0;
      shift_q    <= '0;
      sda_oe_q   <= 1'b0;
      first_q    <= 1'b0;
      cmd_q      <= '0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (ovf_clr) ovf_q <= 1'b0;
      if (start_det) begin
        state_q    <= ST_ADDR;
        bit_cnt_q  <= '0;
        byte_rdy_q <= 1'b0;
        sda_oe_q   <= 1'b0;
        first_q    <= 1'b0;
        busy_q     <= 1'b1;
      end else if (stop_det) begin
        state_q    <= ST_IDLE;
        bit_cnt_q  <= '0;
        byte_rdy_q <= 1'b0;
        sda_oe_q   <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          ST_ADDR, ST_DATA: begin
            if (scl_fall && byte_rdy_q) begin
              byte_rdy_q <= 1'b0;
              if (state_q == ST_ADDR) begin
                if (shift_q[7:1] == SLAVE_ADDR && !shift_q[0]) begin
                  state_q  <= ST_ADDR_ACK;
                  sda_oe_q <= 1'b1;
                  first_q  <= 1'b1;
                end else begin
                  state_q <= ST_IGNORE;
                end
              end else begin
                state_q <= ST_DATA_ACK;
                if (!fifo_full) begin
                  sda_oe_q <= 1'b1;
                  if (first_q) begin
                    cmd_q   <= shift_q;
                    first_q <= 1'b0;
                  end
                end else begin
                  sda_oe_q <= 1'b0;
                  ovf_q    <= 1'b1;
                end
              end
            end else if (scl_rise && !byte_rdy_q) begin
              shift_q   <= {shift_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) byte_rdy_q <= 1'b1;
            end
          end
          ST_ADDR_ACK, ST_DATA_ACK: begin
            if (scl_fall) begin
              state_q   <= ST_DATA;
              sda_oe_q  <= 1'b0;
              bit_cnt_q <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_    (rst_),
    .push_i  (push_w),
    .data_i  (shift_q),
    .pop_i   (out_rtr),
    .data_o  (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt_o)
  );

  assign out_rts  = ~fifo_empty;
  assign sda_oe   = sda_oe_q;
  assign cmd      = cmd_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-banged I2C master, FIFO scoreboard, and a
// transaction-level model of which bytes are ACKed and where they land.
module tb_i2c_slave_rx;
  import i2c_defs::*;

  localparam int DEPTH = 4;
  localparam int Q     = 10;   // clk cycles per quarter SCL period
  localparam logic [6:0] ADDR = 7'h42;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  logic       scl_drv, sda_drv;
  wire logic  sda_in;
  logic       sda_oe, out_rts, out_rtr, busy, overflow, ovf_clr;
  logic [7:0] out_data, cmd;
  i2c_state_e state;
  logic [$clog2(DEPTH):0] fifo_cnt;

  // Open-drain bus: the slave can only pull SDA low.
  assign sda_in = sda_drv & ~sda_oe;

  i2c_slave_rx #(.SLAVE_ADDR(ADDR), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .scl_in     (scl_drv),
    .sda_in     (sda_in),
    .sda_oe     (sda_oe),
    .out_rts    (out_rts),
    .out_rtr    (out_rtr),
    .out_data   (out_data),
    .cmd        (cmd),
    .busy       (busy),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .state_o    (state),
    .fifo_cnt_o (fifo_cnt)
  );

  // ---------------- scoreboard / model state ----------------
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_cmd = 8'h00;
  logic       exp_ovf = 1'b0;
  bit         addressed = 0;
  bit         first_pending = 0;
  bit         oe_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every FIFO pop must match the oldest byte the model accepted.
  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1;
    if (rst_ && out_rts && out_rtr) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL fifo_pop: got unexpected byte 0x%0h, expected none", out_data);
      end else begin
        check("fifo_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // Watchdog.
  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    sda_drv = 1'b0; wait_clk(Q);
    scl_drv = 1'b0; wait_clk(Q);
    addressed     = 0;
    first_pending = 0;
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    sda_drv = 1'b1; wait_clk(2*Q);
    addressed = 0;
  endtask

  task automatic write_bit(input logic b);
    sda_drv = b;    wait_clk(Q);
    scl_drv = 1'b1; wait_clk(2*Q);
    scl_drv = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string name);
    logic got;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    sda_drv = 1'b1; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    got = sda_oe;   wait_clk(Q);
    scl_drv = 1'b0; wait_clk(Q);
    check(name, {31'd0, got}, {31'd0, exp_ack});
  endtask

  task automatic send_addr(input logic [6:0] a, input logic rw);
    logic acc;
    acc = (a == ADDR) && !rw;
    write_byte({a, rw}, acc, "addr_ack");
    addressed = acc;
    if (acc) first_pending = 1;
  endtask

  // Model: an addressed byte is ACKed iff the FIFO has room before it arrives.
  task automatic send_data(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    if (addressed) begin
      if (exp_q.size() < DEPTH) begin
        acc = 1'b1;
        exp_q.push_back(b);
        if (first_pending) begin
          exp_cmd       = b;
          first_pending = 0;
        end
      end else begin
        exp_ovf = 1'b1;
      end
    end
    write_byte(b, acc, "data_ack");
  endtask

  task automatic pulse_ovf_clr();
    @(negedge clk) ovf_clr = 1'b1;
    @(negedge clk) ovf_clr = 1'b0;
    exp_ovf = 1'b0;
  endtask

  task automatic set_rtr(input logic v);
    @(negedge clk) out_rtr = v;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0] ra;
    int         kind, nb;
    rst_ = 1'b0; scl_drv = 1'b1; sda_drv = 1'b1; out_rtr = 1'b0; ovf_clr = 1'b0;
    wait_clk(5);
    check("rst_sda_oe",   {31'd0, sda_oe},   0);
    check("rst_out_rts",  {31'd0, out_rts},  0);
    check("rst_out_data", {24'd0, out_data}, 0);
    check("rst_cmd",      {24'd0, cmd},      0);
    check("rst_busy",     {31'd0, busy},     0);
    check("rst_overflow", {31'd0, overflow}, 0);
    check("rst_state",    {29'd0, state},    {29'd0, ST_IDLE});
    rst_ = 1'b1;
    wait_clk(5);

    // Test-pattern command: 0x08 then 0x01, consumer always ready.
    set_rtr(1'b1);
    i2c_start();
    check("busy_after_start", {31'd0, busy}, 1);
    send_addr(ADDR, 1'b0);
    send_data(CMD_TEST_PATTERN);
    send_data(8'h01);
    i2c_stop();
    wait_clk(10);
    check("cmd_test_pattern", {24'd0, cmd}, {24'd0, exp_cmd});
    check("busy_after_stop",  {31'd0, busy}, 0);
    check("drained_1",        exp_q.size(), 0);

    // Foreign address: never ACKed, nothing stored.
    oe_seen = 0;
    i2c_start();
    send_addr(7'h43, 1'b0);
    check("ign_state_a", {29'd0, state}, {29'd0, ST_IGNORE});
    for (int i = 0; i < 3; i++) send_data(8'hA0 + 8'(i));
    check("ign_state_b", {29'd0, state}, {29'd0, ST_IGNORE});
    i2c_stop();
    wait_clk(5);
    check("ign_oe_seen", {31'd0, oe_seen}, 0);
    check("ign_cmd",     {24'd0, cmd}, {24'd0, exp_cmd});
    check("ign_cnt",     {28'd0, fifo_cnt}, 0);
    check("ign_idle",    {29'd0, state}, {29'd0, ST_IDLE});

    // Read request to our address: NACK.
    i2c_start();
    send_addr(ADDR, 1'b1);
    check("rd_state", {29'd0, state}, {29'd0, ST_IGNORE});
    i2c_stop();

    // Overflow: six bytes into a stalled consumer.
    set_rtr(1'b0);
    i2c_start();
    send_addr(ADDR, 1'b0);
    for (int i = 0; i < 6; i++) send_data(8'h10 + 8'(i));
    i2c_stop();
    wait_clk(5);
    check("ovf_set", {31'd0, overflow}, {31'd0, exp_ovf});
    check("ovf_cnt", {28'd0, fifo_cnt}, DEPTH);
    set_rtr(1'b1);
    wait_clk(20);
    check("ovf_drained", exp_q.size(), 0);
    check("ovf_rts",     {31'd0, out_rts}, 0);
    check("ovf_last",    {24'd0, out_data}, 8'h13);
    pulse_ovf_clr();
    wait_clk(2);
    check("ovf_clr", {31'd0, overflow}, {31'd0, exp_ovf});

    // Repeated START after 5 data bits drops the partial byte.
    set_rtr(1'b0);
    i2c_start();
    send_addr(ADDR, 1'b0);
    send_data(8'h20);
    for (int i = 7; i >= 3; i--) write_bit(1'b1 ^ i[0]);
    i2c_start();
    send_addr(ADDR, 1'b0);
    send_data(CMD_LINE_DRAW);
    i2c_stop();
    wait_clk(5);
    check("rs_cmd", {24'd0, cmd}, {24'd0, exp_cmd});
    check("rs_cnt", {28'd0, fifo_cnt}, exp_q.size());
    set_rtr(1'b1);
    wait_clk(20);
    check("rs_drained", exp_q.size(), 0);

    // Randomized transactions against the model.
    for (int t = 0; t < 10; t++) begin
      kind = $urandom_range(0, 3);
      nb   = $urandom_range(1, 5);
      set_rtr(1'($urandom_range(0, 1)));
      wait_clk(10);
      i2c_start();
      if (kind <= 1) send_addr(ADDR, 1'b0);
      else if (kind == 2) send_addr(ADDR, 1'b1);
      else begin
        ra = 7'($urandom_range(0, 127));
        if (ra == ADDR) ra = ra + 7'd1;
        send_addr(ra, 1'b0);
      end
      for (int i = 0; i < nb; i++) send_data(8'($urandom_range(0, 255)));
      i2c_stop();
      wait_clk(5);
      check("rnd_busy", {31'd0, busy}, 0);
      check("rnd_cmd",  {24'd0, cmd}, {24'd0, exp_cmd});
      check("rnd_ovf",  {31'd0, overflow}, {31'd0, exp_ovf});
      check("rnd_cnt",  {28'd0, fifo_cnt}, exp_q.size());
      if ($urandom_range(0, 1) == 1) pulse_ovf_clr();
      if ($urandom_range(0, 1) == 1) begin
        set_rtr(1'b1);
        wait_clk(20);
      end
    end
    set_rtr(1'b1);
    wait_clk(20);
    check("rnd_drained", exp_q.size(), 0);

    // Reset while the slave is ACKing a data byte.
    set_rtr(1'b0);
    i2c_start();
    send_addr(ADDR, 1'b0);
    send_data(8'h55);
    for (int i = 7; i >= 0; i--) write_bit(i[0]);
    check("pre_rst_state", {29'd0, state}, {29'd0, ST_DATA_ACK});
    check("pre_rst_oe",    {31'd0, sda_oe}, 1);
    rst_ = 1'b0;
    #1;
    check("async_oe_release", {31'd0, sda_oe}, 0);
    exp_q.delete();
    exp_cmd = 8'h00;
    exp_ovf = 1'b0;
    scl_drv = 1'b1; sda_drv = 1'b1;
    wait_clk(3);
    check("rst_mid_rts",   {31'd0, out_rts}, 0);
    check("rst_mid_cnt",   {28'd0, fifo_cnt}, 0);
    check("rst_mid_cmd",   {24'd0, cmd}, {24'd0, exp_cmd});
    check("rst_mid_state", {29'd0, state}, {29'd0, ST_IDLE});
    rst_ = 1'b1;
    wait_clk(10);

    // Still functional after reset.
    set_rtr(1'b1);
    i2c_start();
    send_addr(ADDR, 1'b0);
    send_data(CMD_ELLIPSE);
    i2c_stop();
    wait_clk(20);
    check("post_rst_cmd", {24'd0, cmd}, {24'd0, exp_cmd});
    check("post_rst_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_slave_rx.md
Name: i2c_slave_rx

Overview:
- Write-only I2C slave front end feeding the command processor's byte stream.
- Deserializes SCL/SDA into bytes and matches the 7-bit slave address.
- Buffers data bytes in a small FIFO and presents them on an rts/rtr byte handshake.
- Latches the first data byte of each write transaction as the current command byte.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit address this slave ACKs.
- FIFO_DEPTH, 4, number of byte entries in the output FIFO; power of 2, minimum 2.
- SYNC_STAGES, 2, synchronizer flops on SCL and SDA inputs; minimum 2.

Ports:
- clk  in  1  system clock; at least 8x SCL frequency.
- rst_  in  1  reset, asynchronous, active-low.
- scl_in  in  1  raw I2C clock pin.
- sda_in  in  1  raw I2C data pin.
- sda_oe  out  1  1 = drive SDA low (open-drain); 0 = release.
- out_rts  out  1  FIFO non-empty; out_data is valid.
- out_rtr  in  1  consumer ready.
- out_data  out  8  FIFO head byte.
- cmd  out  8  first data byte of the most recent accepted write transaction.
- busy  out  1  high from START to STOP.
- overflow  out  1  sticky: a data byte was NACKed because the FIFO was full.
- ovf_clr  in  1  synchronous clear of overflow.

Behaviour:
- Reset values: sda_oe=0, out_rts=0, out_data=0, cmd=0, busy=0, overflow=0. FSM goes to IDLE and the FIFO empties.
- Reset is honoured mid-transfer. sda_oe releases immediately (asynchronously).
- Input conditioning:
  - SCL and SDA pass through SYNC_STAGES flops, plus one history flop each for edge detection.
  - All protocol decisions use synchronized signals only.
- Bus conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are detected in any state and override the current state.
  - START (including repeated START) goes to ADDR with bit count 0 and busy=1.
  - STOP goes to IDLE with busy=0.
  - A partially shifted byte is discarded.
- Bit sampling: on each synchronized SCL rising edge, shift SDA in MSB-first and increment the 3-bit bit count.
- FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - IDLE: waits for START.
  - ADDR → ADDR_ACK:
    - Transition happens at the SCL falling edge after the 8th bit.
    - If addr[7:1]==SLAVE_ADDR and R/W=0: set sda_oe=1 and mark the transaction first-byte flag.
    - Otherwise (mismatch or read request): sda_oe stays 0 and the next state is IGNORE.
  - ADDR_ACK → DATA: at the next SCL falling edge, sda_oe=0 and bit count clears.
  - DATA → DATA_ACK, at the SCL falling edge after the 8th bit:
    - If the FIFO count is below FIFO_DEPTH in that clk cycle: push the byte and set sda_oe=1.
      - If the first-byte flag is set, load cmd with the byte and clear the flag.
    - Otherwise: no push, sda_oe=0 (NACK), overflow=1.
  - DATA_ACK → DATA: at the next SCL falling edge, sda_oe=0.
  - IGNORE: never drives SDA; leaves only on START or STOP.
- FIFO and handshake:
  - out_rts = (count != 0). out_data = head entry.
  - A pop occurs when out_rts & out_rtr.
  - Push and pop may occur in the same cycle; count is then unchanged.
  - The full check for a push uses the pre-pop count, so a simultaneous pop does not rescue a push into a full FIFO.
  - Pointers wrap modulo FIFO_DEPTH.
  - While out_rts=0, out_data holds its last value; consumers must qualify with out_rts.
- overflow:
  - Set on any NACKed data byte.
  - Cleared by ovf_clr.
  - If set and clear coincide, set wins.
- Bytes accepted before a STOP remain in the FIFO; STOP and START never flush it.

Decomposition:
- Shared package i2c_defs:
  - FSM state encodings.
  - Default SLAVE_ADDR constant.
  - Command IDs shared with the command processor: circle 1, ellipse 2, line draw 4, test pattern 8, soft reset 16.
- One sub-module, byte_fifo (parameterized width/depth; push, pop, full, empty, count).
  - Reused later for engine-side buffering.
- Synchronizer and edge detection stay inline.

Test Plan:
- Write to 0x42 with bytes 0x08, 0x01 (test-pattern command), out_rtr=1:
  - ACK on the address and both data bytes.
  - out_rts pulses twice with out_data 0x08 then 0x01.
  - cmd=0x08; busy falls after STOP.
- Address 0x43 followed by 3 bytes:
  - sda_oe never asserts.
  - No FIFO pushes, cmd unchanged.
  - FSM stays in IGNORE until STOP.
- Read request (0x42, R/W=1): NACK, no push, IGNORE state.
- out_rtr=0, write 6 bytes 0x10..0x15:
  - The first 4 are ACKed and the 5th and 6th are NACKed; overflow=1.
  - Raising out_rtr drains 0x10..0x13 in order.
  - ovf_clr clears overflow.
- Repeated START mid-byte (after 5 data bits), then a new write 0x42 / 0x04:
  - The partial byte is dropped.
  - cmd=0x04; the FIFO holds only the previously accepted bytes plus 0x04.
- rst_ asserted during DATA_ACK: sda_oe drops asynchronously, FIFO empties, cmd=0, FSM in IDLE.
